// File: rtl/irq_timer_bank.sv
// irq_timer_bank: NUM_CH independent periodic / one-shot interrupt timers.
// Each channel keeps a counter, a latched period, a pending flag and a sticky
// overrun flag. Flags are registered and fed to the interrupt controller.
module irq_timer_bank #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 27
) (
   input  logic                      clk,
   input  logic                      srst,
   input  logic [NUM_CH-1:0]         en,
   input  logic [NUM_CH-1:0]         oneshot,
   input  logic [NUM_CH*CNT_W-1:0]   period,
   input  logic [NUM_CH-1:0]         irq_ack,
   input  logic [NUM_CH-1:0]         ovr_clr,
   output logic [NUM_CH-1:0]         irq,
   output logic                      irq_any,
   output logic [NUM_CH-1:0]         overrun,
   output logic [CNT_W-1:0]          cnt_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           st_q  [NUM_CH];
   state_t           st_d  [NUM_CH];
   logic [CNT_W-1:0] cnt_q [NUM_CH];
   logic [CNT_W-1:0] cnt_d [NUM_CH];
   logic [CNT_W-1:0] per_q [NUM_CH];
   logic [CNT_W-1:0] per_d [NUM_CH];
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] ovr_q, ovr_d;
   logic [NUM_CH-1:0] term;
   logic              irq_any_q;

   // State and data registers for every channel, plus the aggregated irq flag.
   always_ff @(posedge clk) begin
      if (srst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            st_q[i]  <= ST_IDLE;
            cnt_q[i] <= '0;
            per_q[i] <= '0;
         end
         pend_q    <= '0;
         ovr_q     <= '0;
         irq_any_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
            per_q[i] <= per_d[i];
         end
         pend_q    <= pend_d;
         ovr_q     <= ovr_d;
         irq_any_q <= |pend_q;
      end
   end

   // Per-channel next state: counting, reload on terminal, pending/overrun update.
   always_comb begin
      term   = '0;
      pend_d = pend_q & ~irq_ack;
      ovr_d  = ovr_q & ~ovr_clr;
      for (int i = 0; i < NUM_CH; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         per_d[i] = per_q[i];
         case (st_q[i])
            ST_IDLE: begin
               cnt_d[i] = '0;
               if (en[i] && (period[i*CNT_W +: CNT_W] != '0)) begin
                  st_d[i]  = ST_RUN;
                  per_d[i] = period[i*CNT_W +: CNT_W];
               end
            end
            ST_RUN: begin
               if (!en[i]) begin
                  st_d[i]  = ST_IDLE;
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == (per_q[i] - CNT_W'(1))) begin
                  term[i]  = 1'b1;
                  cnt_d[i] = '0;
                  per_d[i] = period[i*CNT_W +: CNT_W];
                  // One-shot takes priority so a zero reload cannot bypass re-arm.
                  if (oneshot[i]) begin
                     st_d[i] = ST_DONE;
                  end else if (period[i*CNT_W +: CNT_W] == '0) begin
                     st_d[i] = ST_IDLE;
                  end
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            ST_DONE: begin
               cnt_d[i] = '0;
               if (!en[i]) begin
                  st_d[i] = ST_IDLE;
               end
            end
            default: begin
               st_d[i]  = ST_IDLE;
               cnt_d[i] = '0;
            end
         endcase
         // A new event always wins over ack; it overruns only if unacknowledged.
         if (term[i]) begin
            pend_d[i] = 1'b1;
            if (pend_q[i] && !irq_ack[i]) begin
               ovr_d[i] = 1'b1;
            end
         end
      end
   end

   assign irq     = pend_q;
   assign irq_any = irq_any_q;
   assign overrun = ovr_q;
   assign cnt_dbg = cnt_q[0];

endmodule

// File: tb/tb_irq_timer_bank.sv
// Directed bench for irq_timer_bank on a 4-channel, 4-bit counter build.
module tb_irq_timer_bank;

   localparam int unsigned NC = 4;
   localparam int unsigned CW = 4;

   logic            clk = 1'b0;
   logic            srst;
   logic [NC-1:0]   en, oneshot, irq_ack, ovr_clr;
   logic [NC*CW-1:0] period;
   logic [NC-1:0]   irq, overrun;
   logic            irq_any;
   logic [CW-1:0]   cnt_dbg;

   int checks = 0;
   int errors = 0;

   irq_timer_bank #(.NUM_CH(NC), .CNT_W(CW)) dut (
      .clk(clk), .srst(srst), .en(en), .oneshot(oneshot), .period(period),
      .irq_ack(irq_ack), .ovr_clr(ovr_clr), .irq(irq), .irq_any(irq_any),
      .overrun(overrun), .cnt_dbg(cnt_dbg)
   );

   always #5 clk = ~clk;

   // One active edge, then settle before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      srst = 1'b1; en = '0; oneshot = '0; irq_ack = '0; ovr_clr = '0; period = '0;
      tick(); tick();
      srst = 1'b0;
      chk("rst_irq", 32'(irq), 0);
      chk("rst_irq_any", 32'(irq_any), 0);
      chk("rst_ovr", 32'(overrun), 0);
      chk("rst_cnt", 32'(cnt_dbg), 0);

      // Periodic ch0, P=4, ack two cycles after each irq.
      period[0 +: 4] = 4'd4; en[0] = 1'b1;
      tick();
      chk("per_cnt_e0", 32'(cnt_dbg), 0);
      for (int c = 1; c <= 12; c++) begin
         irq_ack[0] = (c % 4 == 2) && (c >= 6);
         tick();
         chk("per_irq", 32'(irq[0]), 32'((c >= 4) && ((c % 4 == 0) || (c % 4 == 1))));
         chk("per_any", 32'(irq_any), 32'((c >= 5) && ((c % 4 == 1) || (c % 4 == 2))));
         chk("per_cnt", 32'(cnt_dbg), 32'(c % 4));
         chk("per_ovr", 32'(overrun), 0);
      end
      irq_ack[0] = 1'b1; en[0] = 1'b0;
      tick();
      irq_ack[0] = 1'b0;
      tick();
      chk("per_off", 32'(irq), 0);

      // One-shot ch1, P=10.
      period[4 +: 4] = 4'd10; oneshot[1] = 1'b1; en[1] = 1'b1;
      tick();
      for (int c = 1; c <= 9; c++) tick();
      chk("os_e9", 32'(irq[1]), 0);
      tick();
      chk("os_e10", 32'(irq[1]), 1);
      irq_ack[1] = 1'b1;
      tick();
      irq_ack[1] = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("os_quiet", 32'(irq[1]), 0);
      end
      en[1] = 1'b0;
      tick();
      en[1] = 1'b1;
      tick();
      for (int c = 1; c <= 9; c++) tick();
      chk("os_rearm_e9", 32'(irq[1]), 0);
      tick();
      chk("os_rearm_e10", 32'(irq[1]), 1);
      en[1] = 1'b0; oneshot[1] = 1'b0; irq_ack[1] = 1'b1;
      tick();
      irq_ack[1] = 1'b0;
      chk("os_cleared", 32'(irq[1]), 0);

      // Overrun and ack/terminal collision on ch2, P=3.
      period[8 +: 4] = 4'd3; en[2] = 1'b1;
      tick();
      tick(); tick();
      chk("ov_e2", 32'(irq[2]), 0);
      tick();
      chk("ov_e3_irq", 32'(irq[2]), 1);
      chk("ov_e3_ovr", 32'(overrun[2]), 0);
      tick(); tick(); tick();
      chk("ov_e6_ovr", 32'(overrun[2]), 1);
      tick(); tick();
      irq_ack[2] = 1'b1;
      tick();
      irq_ack[2] = 1'b0;
      chk("ov_e9_irq", 32'(irq[2]), 1);
      chk("ov_e9_ovr", 32'(overrun[2]), 1);
      ovr_clr[2] = 1'b1;
      tick();
      ovr_clr[2] = 1'b0;
      chk("ov_clr", 32'(overrun[2]), 0);
      chk("ov_clr_irq", 32'(irq[2]), 1);
      tick();
      irq_ack[2] = 1'b1;
      tick();
      irq_ack[2] = 1'b0;
      chk("ov_e12_irq", 32'(irq[2]), 1);
      chk("ov_e12_ovr", 32'(overrun[2]), 0);
      en[2] = 1'b0; irq_ack[2] = 1'b1;
      tick();
      irq_ack[2] = 1'b0;
      chk("ov_off", 32'(irq[2]), 0);

      // Period zero never fires.
      period[12 +: 4] = 4'd0; en[3] = 1'b1;
      for (int c = 0; c < 100; c++) begin
         tick();
         chk("p0_quiet", 32'(irq[3]), 0);
      end
      en[3] = 1'b0;
      tick();

      // Period one: event every cycle, overrun at E2, ack cannot lower irq.
      period[12 +: 4] = 4'd1; en[3] = 1'b1;
      tick();
      tick();
      chk("p1_e1_irq", 32'(irq[3]), 1);
      chk("p1_e1_ovr", 32'(overrun[3]), 0);
      tick();
      chk("p1_e2_ovr", 32'(overrun[3]), 1);
      irq_ack[3] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("p1_ack_irq", 32'(irq[3]), 1);
      end
      en[3] = 1'b0;
      tick();
      chk("p1_off_irq", 32'(irq[3]), 0);
      irq_ack[3] = 1'b0; ovr_clr[3] = 1'b1;
      tick();
      ovr_clr[3] = 1'b0;
      chk("p1_off_ovr", 32'(overrun[3]), 0);

      // Maximum period 15 on ch0.
      period[0 +: 4] = 4'd15; en[0] = 1'b1;
      tick();
      for (int c = 1; c <= 30; c++) begin
         irq_ack[0] = (c == 16);
         tick();
         chk("pmax_irq", 32'(irq[0]), 32'((c == 15) || (c == 30)));
         chk("pmax_cnt", 32'(cnt_dbg), 32'(c % 15));
      end
      en[0] = 1'b0; irq_ack[0] = 1'b1;
      tick();
      irq_ack[0] = 1'b0;
      tick();

      // Period change 4 -> 6 mid-interval on ch0.
      period[0 +: 4] = 4'd4; en[0] = 1'b1;
      tick();
      for (int c = 1; c <= 10; c++) begin
         if (c == 3) period[0 +: 4] = 4'd6;
         irq_ack[0] = (c == 5);
         tick();
         chk("pchg_irq", 32'(irq[0]), 32'((c == 4) || (c == 10)));
         chk("pchg_cnt", 32'(cnt_dbg), (c <= 4) ? 32'(c % 4) : 32'((c - 4) % 6));
      end
      en[0] = 1'b0; irq_ack[0] = 1'b1;
      tick();
      irq_ack[0] = 1'b0;
      tick();

      // Reset mid-interval with ch3 also pending/overrun.
      period[0 +: 4] = 4'd8; period[12 +: 4] = 4'd1; en[0] = 1'b1; en[3] = 1'b1;
      tick();
      for (int c = 1; c <= 5; c++) tick();
      chk("rm_cnt5", 32'(cnt_dbg), 5);
      chk("rm_ovr_pre", 32'(overrun[3]), 1);
      srst = 1'b1; en[3] = 1'b0;
      tick();
      srst = 1'b0;
      chk("rm_irq", 32'(irq), 0);
      chk("rm_any", 32'(irq_any), 0);
      chk("rm_ovr", 32'(overrun), 0);
      chk("rm_cnt", 32'(cnt_dbg), 0);
      tick();
      for (int c = 1; c <= 7; c++) tick();
      chk("rm_e7_irq", 32'(irq[0]), 0);
      chk("rm_e7_cnt", 32'(cnt_dbg), 7);
      tick();
      chk("rm_e8_irq", 32'(irq[0]), 1);

      // en drop with irq pending: pend survives, re-enable restarts period.
      tick(); tick();
      chk("ed_cnt2", 32'(cnt_dbg), 2);
      en[0] = 1'b0;
      tick();
      chk("ed_cnt0", 32'(cnt_dbg), 0);
      chk("ed_irq_held", 32'(irq[0]), 1);
      tick();
      chk("ed_irq_held2", 32'(irq[0]), 1);
      irq_ack[0] = 1'b1;
      tick();
      irq_ack[0] = 1'b0;
      chk("ed_ack", 32'(irq[0]), 0);
      en[0] = 1'b1;
      tick();
      for (int c = 1; c <= 7; c++) tick();
      chk("ed_e7_irq", 32'(irq[0]), 0);
      tick();
      chk("ed_e8_irq", 32'(irq[0]), 1);
      chk("ed_ovr", 32'(overrun), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
